// File: rtl/hilo_mult_ctrl_if.sv
// EX-stage <-> Hi/Lo multiply sequencer signal bundle.
// The master drives the instruction; the slave returns status and product.
interface hilo_mult_ctrl_if #(
  parameter int WIDTH = 32
);
  logic               op_valid;
  logic [5:0]         funct;
  logic [WIDTH-1:0]   src_a;
  logic [WIDTH-1:0]   src_b;
  logic               busy;
  logic               stall;
  logic               hilo_we;
  logic [2*WIDTH-1:0] mult_ans;

  modport master (
    output op_valid, funct, src_a, src_b,
    input  busy, stall, hilo_we, mult_ans
  );

  modport slave (
    input  op_valid, funct, src_a, src_b,
    output busy, stall, hilo_we, mult_ans
  );
endinterface

// File: rtl/hilo_mult_ctrl.sv
// Iterative unsigned shift-add MULTU sequencer for the Hi/Lo pair.
// It stalls Hi/Lo users while a product is still being formed.
module hilo_mult_ctrl #(
  parameter int         WIDTH   = 32,
  parameter logic [5:0] F_MULTU = 6'd25,
  parameter logic [5:0] F_MFHI  = 6'd16,
  parameter logic [5:0] F_MFLO  = 6'd18
) (
  input  logic             clk,
  input  logic             reset,
  hilo_mult_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] mult_ans_q, mult_ans_d;
  logic               hilo_we_q, hilo_we_d;
  logic               busy_q, busy_d;

  logic               hilo_op_s;
  logic               start_s;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] step_s;

  assign hilo_op_s = bus.op_valid &&
                     ((bus.funct == F_MULTU) || (bus.funct == F_MFHI) ||
                      (bus.funct == F_MFLO));
  assign start_s   = bus.op_valid && (bus.funct == F_MULTU) && (state_q == IDLE);

  // One shift-add step: conditionally add the multiplicand into the high half,
  // keep its carry, then shift the whole accumulator right by one.
  assign sum_s  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                  (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign step_s = {sum_s, prod_q[WIDTH-1:1]};

  assign bus.stall    = reset && hilo_op_s && (state_q != IDLE);
  assign bus.busy     = busy_q;
  assign bus.hilo_we  = hilo_we_q;
  assign bus.mult_ans = mult_ans_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mcand_d    = mcand_q;
    prod_d     = prod_q;
    mult_ans_d = mult_ans_q;
    hilo_we_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d = RUN;
          mcand_d = bus.src_a;
          prod_d  = {{WIDTH{1'b0}}, bus.src_b};
          count_d = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        prod_d  = step_s;
        count_d = count_q + ONE;
        // The product is published on entry to WRITE so it is already valid
        // while the write strobe is high.
        if (count_q == LAST) begin
          state_d    = WRITE;
          mult_ans_d = step_s;
          hilo_we_d  = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      WRITE: begin
        state_d = IDLE;
        count_d = {CW{1'b0}};
      end
      default: begin
        state_d = IDLE;
        count_d = {CW{1'b0}};
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= {CW{1'b0}};
      mcand_q    <= {WIDTH{1'b0}};
      prod_q     <= {(2*WIDTH){1'b0}};
      mult_ans_q <= {(2*WIDTH){1'b0}};
      hilo_we_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      mcand_q    <= mcand_d;
      prod_q     <= prod_d;
      mult_ans_q <= mult_ans_d;
      hilo_we_q  <= hilo_we_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Directed bench for hilo_mult_ctrl: reset, products, stall behaviour,
// back-to-back MULTU and reset abort, all against hand-computed values.
module tb_hilo_mult_ctrl;

  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_ADD   = 6'd32;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  hilo_mult_ctrl_if #(.WIDTH(32)) bus ();

  hilo_mult_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_bus();
    bus.op_valid = 1'b0;
    bus.funct    = F_ADD;
  endtask

  // Count busy cycles and write pulses over a window after acceptance.
  task automatic watch(input string tag, input logic [63:0] exp,
                       input int exp_busy);
    int busy_cnt = 0;
    int we_cnt   = 0;
    int b2b      = 0;
    logic prev_we = 1'b0;
    logic [63:0] ans_at_we = 64'd0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.hilo_we) begin
        we_cnt++;
        ans_at_we = bus.mult_ans;
        if (prev_we) b2b++;
      end
      prev_we = bus.hilo_we;
      cyc();
    end
    check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
    check_eq({tag, "_we_pulses"}, 64'(we_cnt), 64'd1);
    check_eq({tag, "_we_b2b"}, 64'(b2b), 64'd0);
    check_eq({tag, "_ans_at_we"}, ans_at_we, exp);
    check_eq({tag, "_ans_hold"}, bus.mult_ans, exp);
  endtask

  task automatic do_mult(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
    bus.op_valid = 1'b1;
    bus.funct    = F_MULTU;
    bus.src_a    = a;
    bus.src_b    = b;
    #1;
    check_eq({tag, "_stall_idle"}, {63'd0, bus.stall}, 64'd0);
    cyc();
    idle_bus();
    bus.src_a = $urandom;
    bus.src_b = $urandom;
    watch(tag, exp, 33);
  endtask

  initial begin
    int stall_cnt;
    n_checks = 0;
    n_errors = 0;
    bus.src_a = 32'd0;
    bus.src_b = 32'd0;
    idle_bus();

    // 1: reset
    reset = 1'b0;
    repeat (3) cyc();
    check_eq("rst_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("rst_stall", {63'd0, bus.stall}, 64'd0);
    check_eq("rst_we", {63'd0, bus.hilo_we}, 64'd0);
    check_eq("rst_ans", bus.mult_ans, 64'd0);
    reset = 1'b1;
    cyc();
    check_eq("rel_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("rel_stall", {63'd0, bus.stall}, 64'd0);
    check_eq("rel_we", {63'd0, bus.hilo_we}, 64'd0);
    check_eq("rel_ans", bus.mult_ans, 64'd0);

    // 2, 3: products
    do_mult("m6x7", 32'd6, 32'd7, 64'd42);
    do_mult("mmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    do_mult("m0xb", 32'd0, 32'd12345, 64'd0);
    do_mult("mhex", 32'h1234_5678, 32'd9, 64'h0000_0000_A3D7_0A38);
    do_mult("mcar", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);

    // 4: stall while running
    bus.op_valid = 1'b1;
    bus.funct    = F_MULTU;
    bus.src_a    = 32'd3;
    bus.src_b    = 32'd3;
    cyc();
    idle_bus();
    repeat (4) cyc();
    bus.op_valid = 1'b1;
    bus.funct    = F_ADD;
    #1;
    check_eq("run_add_stall", {63'd0, bus.stall}, 64'd0);
    bus.funct = F_MFLO;
    #1;
    check_eq("run_mflo_stall", {63'd0, bus.stall}, 64'd1);
    bus.funct = F_MFHI;
    #1;
    check_eq("run_mfhi_stall", {63'd0, bus.stall}, 64'd1);
    stall_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (!bus.stall) break;
      stall_cnt++;
      cyc();
    end
    check_eq("mfhi_stall_cycles", 64'(stall_cnt), 64'd29);
    check_eq("mfhi_after_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("mfhi_after_ans", bus.mult_ans, 64'd9);
    idle_bus();
    cyc();

    // 5: MULTU presented during WRITE
    bus.op_valid = 1'b1;
    bus.funct    = F_MULTU;
    bus.src_a    = 32'd3;
    bus.src_b    = 32'd5;
    cyc();
    idle_bus();
    for (int i = 0; i < 60; i++) begin
      if (bus.hilo_we) break;
      cyc();
    end
    check_eq("b2b_first_we", {63'd0, bus.hilo_we}, 64'd1);
    check_eq("b2b_first_ans", bus.mult_ans, 64'd15);
    bus.op_valid = 1'b1;
    bus.funct    = F_MULTU;
    bus.src_a    = 32'd4;
    bus.src_b    = 32'd4;
    #1;
    check_eq("b2b_write_stall", {63'd0, bus.stall}, 64'd1);
    cyc();
    check_eq("b2b_idle_stall", {63'd0, bus.stall}, 64'd0);
    check_eq("b2b_idle_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("b2b_idle_we", {63'd0, bus.hilo_we}, 64'd0);
    cyc();
    idle_bus();
    watch("b2b_second", 64'd16, 33);

    // 6: reset in the middle of RUN
    bus.op_valid = 1'b1;
    bus.funct    = F_MULTU;
    bus.src_a    = 32'd100;
    bus.src_b    = 32'd200;
    cyc();
    repeat (9) cyc();
    check_eq("abort_pre_busy", {63'd0, bus.busy}, 64'd1);
    reset = 1'b0;
    #1;
    check_eq("abort_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("abort_stall", {63'd0, bus.stall}, 64'd0);
    check_eq("abort_ans", bus.mult_ans, 64'd0);
    idle_bus();
    stall_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.hilo_we) stall_cnt++;
      cyc();
    end
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.hilo_we) stall_cnt++;
      cyc();
    end
    check_eq("abort_no_we", 64'(stall_cnt), 64'd0);
    check_eq("abort_idle_ans", bus.mult_ans, 64'd0);
    do_mult("m2x9", 32'd2, 32'd9, 64'd18);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
